// File: rtl/tia_pkg.sv
// Shared constants for the two-phase polynomial counters: phase slot encodings
// and the default shape of the horizontal counter.
`timescale 1ns/1ps
package tia_pkg;

  // Phase-register values during which each clock phase is active.
  localparam logic [1:0] PH_PHI1 = 2'd0;
  localparam logic [1:0] PH_PHI2 = 2'd2;

  // Horizontal counter defaults: 6 stages, taps on bits 0 and 1, wrap after 010100.
  localparam int unsigned HCTR_WIDTH = 6;
  localparam logic [5:0]  HCTR_TAPS  = 6'b000011;
  localparam logic [5:0]  HCTR_WRAP  = 6'b010100;

endpackage

// File: rtl/tia_d2_stage.sv
// Single-bit two-phase cell: phi1 captures the inverted input into the tap
// latch, phi2 moves the inverted tap into the output stage.
`timescale 1ns/1ps
module tia_d2_stage (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic phi1_i,
  input  logic phi2_i,
  input  logic load_i,
  input  logic load_bit_i,
  input  logic in_i,
  output logic tap_o,
  output logic out_o
);

  logic tap_q, tap_d;
  logic out_q, out_d;

  // Next-state: load overrides both phases; tap is kept equal to ~out on load.
  always_comb begin
    tap_d = tap_q;
    out_d = out_q;
    if (load_i) begin
      out_d = load_bit_i;
      tap_d = ~load_bit_i;
    end else begin
      if (phi1_i) tap_d = ~in_i;
      if (phi2_i) out_d = ~tap_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tap_q <= 1'b1;
      out_q <= 1'b0;
    end else begin
      tap_q <= tap_d;
      out_q <= out_d;
    end
  end

  assign tap_o = tap_q;
  assign out_o = out_q;

endmodule

// File: rtl/tia_poly_ctr.sv
// Two-phase polynomial (XNOR-feedback shift) counter with a programmable wrap
// value. A 2-bit phase register sequences phi1/phi2; one count step takes four
// enabled clocks.
`timescale 1ns/1ps
module tia_poly_ctr
  import tia_pkg::*;
#(
  parameter int unsigned          WIDTH      = HCTR_WIDTH,
  parameter logic [WIDTH-1:0]     TAP_MASK   = WIDTH'(HCTR_TAPS),
  parameter logic [WIDTH-1:0]     WRAP_VALUE = WIDTH'(HCTR_WRAP)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] tap,
  output logic             phi1,
  output logic             phi2,
  output logic             wrap
);

  logic [1:0]       ph_q, ph_d;
  logic             wrap_pend_q, wrap_pend_d;
  logic             wrap_q, wrap_d;
  logic             fb;
  logic             wrap_hit;
  logic [WIDTH-1:0] stage_in;

  assign phi1 = enable & (ph_q == PH_PHI1);
  assign phi2 = enable & (ph_q == PH_PHI2);

  // Feedback and per-stage inputs; a wrap forces every tap to one so that
  // the following phi2 drives count to zero.
  always_comb begin
    fb       = ~^(count & TAP_MASK);
    wrap_hit = (count == WRAP_VALUE);
    stage_in = {count[WIDTH-2:0], fb};
    if (wrap_hit) stage_in = '0;
  end

  // Phase sequencing and wrap bookkeeping; wrap is a single-edge pulse.
  always_comb begin
    ph_d        = ph_q;
    wrap_pend_d = wrap_pend_q;
    wrap_d      = 1'b0;
    if (load) begin
      ph_d        = PH_PHI1;
      wrap_pend_d = 1'b0;
    end else begin
      if (enable) ph_d = ph_q + 2'd1;
      if (phi1 && wrap_hit) wrap_pend_d = 1'b1;
      if (phi2 && wrap_pend_q) begin
        wrap_d      = 1'b1;
        wrap_pend_d = 1'b0;
      end
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ph_q        <= PH_PHI1;
      wrap_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      wrap_pend_q <= wrap_pend_d;
      wrap_q      <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tia_d2_stage u_stage (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .phi1_i     (phi1),
      .phi2_i     (phi2),
      .load_i     (load),
      .load_bit_i (load_value[i]),
      .in_i       (stage_in[i]),
      .tap_o      (tap[i]),
      .out_o      (count[i])
    );
  end

endmodule

// File: tb/tb_tia_poly_ctr.sv
// Scoreboard bench for tia_poly_ctr: stimulus pushes per-cycle expectations
// (from a step-level model and hand-computed constants); a negedge monitor
// pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_tia_poly_ctr;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_value = '0;
  logic [5:0] count, tap;
  logic       phi1, phi2, wrap;

  tia_poly_ctr dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tap        (tap),
    .phi1       (phi1),
    .phi2       (phi2),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  // kind: 0 = all outputs, 1 = count only, 2 = wrap only
  typedef struct {
    string      name;
    int         cyc;
    int         kind;
    logic [5:0] count;
    logic [5:0] tap;
    logic       phi1;
    logic       phi2;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        check({e.name, "_stale"}, e.cyc, cyc);
      end else begin
        if (e.kind == 0 || e.kind == 1) check({e.name, "_count"}, int'(count), int'(e.count));
        if (e.kind == 0) begin
          check({e.name, "_tap"},  int'(tap),  int'(e.tap));
          check({e.name, "_phi1"}, int'(phi1), int'(e.phi1));
          check({e.name, "_phi2"}, int'(phi2), int'(e.phi2));
        end
        if (e.kind == 0 || e.kind == 2) check({e.name, "_wrap"}, int'(wrap), int'(e.wrap));
      end
    end
  end

  // Step-level reference model (6 bits, taps 000011, wrap 010100).
  logic [1:0] m_ph;
  logic [5:0] m_count, m_tap;
  logic       m_pend, m_wrap;
  bit         m_valid = 0;
  string      cur_name = "init";

  function automatic logic [5:0] next_count(input logic [5:0] c);
    return {c[4:0], ~^(c & 6'b000011)};
  endfunction

  task automatic apply(input logic r, input logic e, input logic l, input logic [5:0] lv);
    exp_t x;
    reset_n = r; enable = e; load = l; load_value = lv;
    if (m_valid) begin
      x = '{cur_name, cyc, 0, m_count, m_tap, e && (m_ph == 2'd0), e && (m_ph == 2'd2), m_wrap};
      q.push_back(x);
    end
    @(posedge clk);
    if (!r) begin
      m_ph = 0; m_count = 0; m_tap = 6'h3f; m_pend = 0; m_wrap = 0; m_valid = 1;
    end else if (l) begin
      m_ph = 0; m_count = lv; m_tap = ~lv; m_pend = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (e) begin
        if (m_ph == 2'd0) begin
          if (m_count == 6'b010100) begin m_tap = 6'h3f; m_pend = 1; end
          else m_tap = ~next_count(m_count);
        end else if (m_ph == 2'd2) begin
          m_count = ~m_tap;
          if (m_pend) begin m_wrap = 1; m_pend = 0; end
        end
        m_ph = m_ph + 2'd1;
      end
    end
    #1;
  endtask

  // Hand-computed expectations for the cycle following the last edge.
  task automatic exp_count(input string name, input logic [5:0] v);
    exp_t x;
    x = '{name, cyc, 1, v, 6'h0, 1'b0, 1'b0, 1'b0};
    q.push_back(x);
  endtask

  task automatic exp_wrap(input string name, input logic v);
    exp_t x;
    x = '{name, cyc, 2, 6'h0, 6'h0, 1'b0, 1'b0, v};
    q.push_back(x);
  endtask

  initial begin
    logic [5:0] seq [4] = '{6'b000001, 6'b000010, 6'b000100, 6'b001001};
    @(posedge clk); #1;

    // Reset then free-running count sequence.
    cur_name = "run";
    apply(0, 1, 0, 0);
    exp_count("rst_count", 6'b000000);
    for (int i = 1; i <= 16; i++) begin
      apply(1, 1, 0, 0);
      if (i % 4 == 3) exp_count("seq", seq[i / 4]);
    end

    // Load with enable low, then wrap on the third enabled edge.
    cur_name = "wrapchk";
    apply(1, 0, 1, 6'b010100);
    exp_count("load_en0", 6'b010100);
    apply(1, 0, 0, 0);
    exp_count("hold_en0", 6'b010100);
    for (int i = 1; i <= 8; i++) begin
      apply(1, 1, 0, 0);
      if (i == 3) begin exp_count("wrap_zero", 6'b000000); exp_wrap("wrap_hi", 1'b1); end
      if (i == 4) exp_wrap("wrap_lo", 1'b0);
      if (i == 7) exp_count("after_wrap", 6'b000001);
    end

    // All-ones lock-up: no movement, never wraps.
    cur_name = "lockup";
    apply(1, 1, 1, 6'b111111);
    for (int i = 0; i < 80; i++) apply(1, 1, 0, 0);
    exp_count("lockup", 6'b111111);

    // Enable dropped for 5 clocks after the phi1 edge delays the update by 5.
    cur_name = "stall";
    apply(0, 1, 0, 0);
    apply(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) apply(1, 0, 0, 0);
    apply(1, 1, 0, 0);
    exp_count("stall_pre", 6'b000000);
    apply(1, 1, 0, 0);
    exp_count("stall_post", 6'b000001);
    apply(1, 1, 0, 0);

    // Reset between phi1 and phi2 while count sits at the wrap value.
    cur_name = "midrst";
    apply(1, 1, 1, 6'b010100);
    apply(1, 1, 0, 0);
    apply(0, 1, 0, 0);
    exp_count("midrst_count", 6'b000000);
    for (int i = 1; i <= 8; i++) begin
      apply(1, 1, 0, 0);
      if (i == 3) begin exp_count("midrst_step", 6'b000001); exp_wrap("midrst_nowrap", 1'b0); end
    end

    // Reset beats load on the same edge.
    cur_name = "rst_vs_load";
    apply(0, 1, 1, 6'b101010);
    exp_count("rst_wins", 6'b000000);
    apply(1, 1, 0, 0);
    apply(1, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
